// File: rtl/uart_op_pkg.sv
// Shared encodings for the UART operation engine: operation modes and FSM states.
package uart_op_pkg;

    typedef enum logic [1:0] {
        MODE_ECHO = 2'b00,
        MODE_SUM  = 2'b01,
        MODE_XOR  = 2'b10,
        MODE_MAX  = 2'b11
    } mode_t;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_EMIT    = 1'b1
    } state_t;

    function automatic logic is_multi_op(input mode_t m);
        return (m != MODE_ECHO);
    endfunction

endpackage

// File: rtl/uart_op_alu.sv
// Per-byte combine: folds one received byte into the running accumulator.
module uart_op_alu
    import uart_op_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ECHO_OFFSET = 1
) (
    input  mode_t                 i_mode,
    input  logic [DATA_WIDTH-1:0] i_acc,
    input  logic [DATA_WIDTH-1:0] i_byte,
    input  logic                  i_first,
    output logic [DATA_WIDTH-1:0] o_next_acc,
    output logic                  o_carry
);

    localparam logic [DATA_WIDTH-1:0] OFFSET = DATA_WIDTH'(ECHO_OFFSET);

    logic [DATA_WIDTH:0]   w_sum;
    logic [DATA_WIDTH-1:0] w_base;

    // The first byte of a frame starts from zero rather than the stale accumulator
    always_comb begin
        w_base     = i_first ? {DATA_WIDTH{1'b0}} : i_acc;
        w_sum      = {1'b0, w_base} + {1'b0, i_byte};
        o_next_acc = i_byte;
        o_carry    = 1'b0;
        case (i_mode)
            MODE_ECHO: o_next_acc = i_byte + OFFSET;
            MODE_SUM: begin
                o_next_acc = w_sum[DATA_WIDTH-1:0];
                o_carry    = w_sum[DATA_WIDTH];
            end
            MODE_XOR:  o_next_acc = w_base ^ i_byte;
            MODE_MAX:  o_next_acc = (i_first || (i_byte > i_acc)) ? i_byte : i_acc;
            default:   o_next_acc = i_byte;
        endcase
    end

endmodule

// File: rtl/uart_op_engine.sv
// Collects frames of RX bytes, combines them per the latched mode and pushes the result to TX.
module uart_op_engine
    import uart_op_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_OPS     = 2,
    parameter int ECHO_OFFSET = 1
) (
    input  logic                  clk_100MHz,
    input  logic                  reset,
    input  logic [1:0]            mode,
    input  logic                  auto_run,
    input  logic                  step_tick,
    input  logic                  clear,
    input  logic                  rx_empty,
    input  logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rd_uart,
    input  logic                  tx_full,
    output logic                  wr_uart,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  result_valid,
    output logic                  overflow,
    output logic                  busy
);

    localparam int CW = $clog2(NUM_OPS + 1);

    state_t                r_state;
    mode_t                 r_mode;
    logic [CW-1:0]         r_count;
    logic [DATA_WIDTH-1:0] r_acc;
    logic                  r_carry;
    logic [DATA_WIDTH-1:0] r_result;
    logic                  r_overflow;
    logic                  r_result_valid;

    logic                  w_first;
    mode_t                 w_mode_eff;
    logic [CW-1:0]         w_len;
    logic                  w_accept;
    logic                  w_last;
    logic                  w_write;
    logic [DATA_WIDTH-1:0] w_next_acc;
    logic                  w_alu_carry;

    // The first byte uses the live mode input because the latch only lands on that edge
    assign w_first    = (r_count == {CW{1'b0}});
    assign w_mode_eff = w_first ? mode_t'(mode) : r_mode;
    assign w_len      = is_multi_op(w_mode_eff) ? CW'(NUM_OPS) : CW'(1);
    assign w_accept   = !reset && (r_state == ST_COLLECT) && !rx_empty
                        && (auto_run || step_tick) && !clear;
    assign w_last     = ((r_count + CW'(1)) == w_len);
    assign w_write    = !reset && (r_state == ST_EMIT) && !tx_full;

    assign rd_uart      = w_accept;
    assign wr_uart      = w_write;
    assign wr_data      = r_acc;
    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign overflow     = r_overflow;
    assign busy         = (r_state == ST_EMIT) || (r_count != {CW{1'b0}});

    uart_op_alu #(
        .DATA_WIDTH  (DATA_WIDTH),
        .ECHO_OFFSET (ECHO_OFFSET)
    ) u_alu (
        .i_mode     (w_mode_eff),
        .i_acc      (r_acc),
        .i_byte     (rx_data),
        .i_first    (w_first),
        .o_next_acc (w_next_acc),
        .o_carry    (w_alu_carry)
    );

    // Frame collection / emission state machine
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            r_state        <= ST_COLLECT;
            r_mode         <= MODE_ECHO;
            r_count        <= {CW{1'b0}};
            r_acc          <= {DATA_WIDTH{1'b0}};
            r_carry        <= 1'b0;
            r_result       <= {DATA_WIDTH{1'b0}};
            r_overflow     <= 1'b0;
            r_result_valid <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            case (r_state)
                ST_COLLECT: begin
                    if (clear) begin
                        r_count <= {CW{1'b0}};
                        r_acc   <= {DATA_WIDTH{1'b0}};
                        r_carry <= 1'b0;
                    end else if (w_accept) begin
                        if (w_first) begin
                            r_mode <= mode_t'(mode);
                        end
                        r_acc   <= w_next_acc;
                        r_carry <= w_first ? w_alu_carry : (r_carry | w_alu_carry);
                        r_count <= r_count + CW'(1);
                        if (w_last) begin
                            r_state <= ST_EMIT;
                        end
                    end
                end
                ST_EMIT: begin
                    if (w_write) begin
                        r_result       <= r_acc;
                        r_overflow     <= r_carry;
                        r_result_valid <= 1'b1;
                        r_count        <= {CW{1'b0}};
                        r_state        <= ST_COLLECT;
                    end
                end
                default: r_state <= ST_COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_op_engine.sv
// Bench for uart_op_engine: frame-level reference model checked every cycle plus literal pins.
module tb_uart_op_engine;

    localparam int DW   = 8;
    localparam int NOPS = 2;
    localparam int OFS  = 1;

    logic          clk = 1'b0;
    logic          reset, auto_run, step_tick, clear;
    logic [1:0]    mode;
    logic          rx_empty, tx_full, rx_empty3, tx_full3;
    logic [DW-1:0] rx_data, rx_data3;
    logic          rd_uart, wr_uart, result_valid, overflow, busy;
    logic [DW-1:0] wr_data, result;
    logic          rd_uart3, wr_uart3, result_valid3, overflow3, busy3;
    logic [DW-1:0] wr_data3, result3;

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] rx_q[$];
    logic [DW-1:0] rx_q3[$];
    logic [DW-1:0] wr_log[$];
    int            wr3_cnt = 0;
    logic [DW-1:0] last_wr3 = 8'h00;

    // Reference model state: a frame is a list of bytes plus the mode seen on its first byte
    logic [DW-1:0] m_bytes[$];
    int            m_mode = 0;
    bit            m_pend = 1'b0;
    logic [DW-1:0] m_val = 8'h00;
    bit            m_ovf_pend = 1'b0;
    logic [DW-1:0] m_res = 8'h00;
    bit            m_ovf = 1'b0;
    bit            m_rv = 1'b0;

    always #5 clk = ~clk;

    uart_op_engine #(.DATA_WIDTH(DW), .NUM_OPS(NOPS), .ECHO_OFFSET(OFS)) dut (
        .clk_100MHz(clk), .reset(reset), .mode(mode), .auto_run(auto_run),
        .step_tick(step_tick), .clear(clear), .rx_empty(rx_empty), .rx_data(rx_data),
        .rd_uart(rd_uart), .tx_full(tx_full), .wr_uart(wr_uart), .wr_data(wr_data),
        .result(result), .result_valid(result_valid), .overflow(overflow), .busy(busy)
    );

    uart_op_engine #(.DATA_WIDTH(DW), .NUM_OPS(3), .ECHO_OFFSET(OFS)) dut3 (
        .clk_100MHz(clk), .reset(reset), .mode(mode), .auto_run(auto_run),
        .step_tick(step_tick), .clear(clear), .rx_empty(rx_empty3), .rx_data(rx_data3),
        .rd_uart(rd_uart3), .tx_full(tx_full3), .wr_uart(wr_uart3), .wr_data(wr_data3),
        .result(result3), .result_valid(result_valid3), .overflow(overflow3), .busy(busy3)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void frame_eval(input int md, input logic [DW-1:0] b[$],
                                       output logic [DW-1:0] v, output bit o);
        int acc;
        acc = 0;
        o   = 1'b0;
        case (md)
            0: acc = (int'(b[0]) + OFS) % 256;
            1: begin
                foreach (b[i]) acc += int'(b[i]);
                o   = (acc > 255);
                acc = acc % 256;
            end
            2: foreach (b[i]) acc = acc ^ int'(b[i]);
            default: foreach (b[i]) if (int'(b[i]) > acc) acc = int'(b[i]);
        endcase
        v = acc[DW-1:0];
    endfunction

    task automatic refresh();
        rx_empty  = (rx_q.size() == 0);
        rx_data   = rx_empty ? 8'h00 : rx_q[0];
        rx_empty3 = (rx_q3.size() == 0);
        rx_data3  = rx_empty3 ? 8'h00 : rx_q3[0];
    endtask

    task automatic push(input logic [DW-1:0] b);
        rx_q.push_back(b);
        refresh();
    endtask

    task automatic push3(input logic [DW-1:0] b);
        rx_q3.push_back(b);
        refresh();
    endtask

    // Compare every DUT output against the frame model, then advance the model one cycle
    task automatic model_cycle();
        bit exp_rd, exp_wr;
        if (reset) begin
            chk("rst_rd_uart", 32'(rd_uart), 32'd0);
            chk("rst_wr_uart", 32'(wr_uart), 32'd0);
            chk("rst_result", 32'(result), 32'd0);
            chk("rst_result_valid", 32'(result_valid), 32'd0);
            chk("rst_overflow", 32'(overflow), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            m_bytes.delete();
            m_pend = 1'b0; m_rv = 1'b0; m_res = 8'h00; m_ovf = 1'b0;
        end else begin
            exp_rd = !m_pend && !rx_empty && (auto_run || step_tick) && !clear;
            exp_wr = m_pend && !tx_full;
            chk("rd_uart", 32'(rd_uart), 32'(exp_rd));
            chk("wr_uart", 32'(wr_uart), 32'(exp_wr));
            if (m_pend) chk("wr_data", 32'(wr_data), 32'(m_val));
            chk("busy", 32'(busy), 32'(m_pend || (m_bytes.size() != 0)));
            chk("result_valid", 32'(result_valid), 32'(m_rv));
            chk("result", 32'(result), 32'(m_res));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            if (wr_uart) wr_log.push_back(wr_data);
            m_rv = 1'b0;
            if (exp_wr) begin
                m_res = m_val; m_ovf = m_ovf_pend; m_rv = 1'b1;
                m_pend = 1'b0; m_bytes.delete();
            end else if (!m_pend && clear) begin
                m_bytes.delete();
            end else if (exp_rd) begin
                if (m_bytes.size() == 0) m_mode = int'(mode);
                m_bytes.push_back(rx_data);
                if (m_bytes.size() == ((m_mode == 0) ? 1 : NOPS)) begin
                    frame_eval(m_mode, m_bytes, m_val, m_ovf_pend);
                    m_pend = 1'b1;
                end
            end
        end
    endtask

    task automatic step();
        bit p, p3;
        @(negedge clk);
        model_cycle();
        p  = rd_uart;
        p3 = rd_uart3;
        if (wr_uart3) begin
            wr3_cnt++;
            last_wr3 = wr_data3;
        end
        @(posedge clk);
        #1;
        if (p && rx_q.size() != 0) void'(rx_q.pop_front());
        if (p3 && rx_q3.size() != 0) void'(rx_q3.pop_front());
        step_tick = 1'b0;
        clear     = 1'b0;
        refresh();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    function automatic logic [DW-1:0] last_wr();
        return (wr_log.size() == 0) ? 8'hXX : wr_log[wr_log.size() - 1];
    endfunction

    initial begin
        int nlog;
        reset = 1'b1; mode = 2'b00; auto_run = 1'b1; step_tick = 1'b0; clear = 1'b0;
        tx_full = 1'b0; tx_full3 = 1'b0;
        refresh();
        steps(3);
        reset = 1'b0;
        steps(2);

        // Echo: 0x41 -> 0x42
        mode = 2'b00;
        push(8'h41);
        steps(5);
        chk("echo_wr", 32'(last_wr()), 32'h42);
        chk("echo_nwr", 32'(wr_log.size()), 32'd1);
        chk("echo_result", 32'(result), 32'h42);

        // Sum without and with carry
        mode = 2'b01;
        push(8'h30); push(8'h05);
        steps(6);
        chk("sum1_wr", 32'(last_wr()), 32'h35);
        chk("sum1_ovf", 32'(overflow), 32'd0);
        push(8'hF0); push(8'h20);
        steps(6);
        chk("sum2_wr", 32'(last_wr()), 32'h10);
        chk("sum2_ovf", 32'(overflow), 32'd1);

        // Manual stepping, xor
        auto_run = 1'b0; mode = 2'b10;
        push(8'h0F); push(8'hFF);
        steps(5);
        chk("man_nopop", 32'(rx_q.size()), 32'd2);
        step_tick = 1'b1; step();
        steps(2);
        step_tick = 1'b1; step();
        steps(4);
        chk("man_xor", 32'(last_wr()), 32'hF0);
        nlog = wr_log.size();
        step_tick = 1'b1; step();
        steps(2);
        chk("man_empty_tick_busy", 32'(busy), 32'd0);
        chk("man_empty_tick_nwr", 32'(wr_log.size()), 32'(nlog));

        // Back-pressure, max, three operands
        auto_run = 1'b1; mode = 2'b11; tx_full3 = 1'b1;
        push3(8'h12); push3(8'h7E); push3(8'h33); push3(8'h55);
        steps(13);
        chk("bp_no_write", 32'(wr3_cnt), 32'd0);
        chk("bp_pops", 32'(rx_q3.size()), 32'd1);
        chk("bp_busy", 32'(busy3), 32'd1);
        tx_full3 = 1'b0;
        steps(5);
        chk("bp_one_write", 32'(wr3_cnt), 32'd1);
        chk("bp_data", 32'(last_wr3), 32'h7E);
        chk("bp_result", 32'(result3), 32'h7E);
        clear = 1'b1; step();
        chk("bp_clear_busy", 32'(busy3), 32'd0);

        // Back-pressure on the two-operand engine, sum
        mode = 2'b01; tx_full = 1'b1;
        push(8'h80); push(8'h90);
        steps(8);
        tx_full = 1'b0;
        steps(4);
        chk("bp2_wr", 32'(last_wr()), 32'h10);
        chk("bp2_ovf", 32'(overflow), 32'd1);

        // Abort via clear, then a clean frame
        push(8'h09);
        steps(3);
        chk("abort_busy_mid", 32'(busy), 32'd1);
        clear = 1'b1; step();
        chk("abort_busy", 32'(busy), 32'd0);
        push(8'h01); push(8'h02);
        steps(6);
        chk("abort_next", 32'(last_wr()), 32'h03);
        chk("abort_ovf", 32'(overflow), 32'd0);

        // Reset while waiting in EMIT drops the frame
        tx_full = 1'b1;
        push(8'h11); push(8'h22);
        steps(4);
        nlog = wr_log.size();
        reset = 1'b1;
        steps(2);
        chk("rst_emit_result", 32'(result), 32'd0);
        reset = 1'b0; tx_full = 1'b0;
        steps(4);
        chk("rst_emit_nwr", 32'(wr_log.size()), 32'(nlog));

        // Mode change mid-frame is ignored
        mode = 2'b01;
        push(8'h03);
        step();
        mode = 2'b10;
        push(8'h03);
        steps(5);
        chk("midmode", 32'(last_wr()), 32'h06);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
